// File: rtl/minmax_pbuf_pkg.sv
// Shared constants for the min/max priority buffer.
//   HIGH / LOW : polarity and mode selectors. For MINMAX_, HIGH means
//                "minimum first" and LOW means "maximum first". For ACT,
//                HIGH means the one-hot output is active high.
package minmax_pbuf_pkg;
    localparam bit HIGH = 1'b1;
    localparam bit LOW  = 1'b0;
endpackage

// File: rtl/sel_minmax.sv
// Combinational min/max selector over IN keys of DATA bits.
//   in_vec  : IN packed keys
//   out_vec : one-hot marker of the winning key. Polarity follows ACT.
// MINMAX_=HIGH picks the smallest key and MINMAX_=LOW picks the largest key.
// On ties, the lowest index wins.
module sel_minmax
    import minmax_pbuf_pkg::*;
#(
    parameter int IN      = 4,
    parameter int DATA    = 8,
    parameter bit MINMAX_ = HIGH,
    parameter bit ACT     = HIGH
) (
    input  logic [IN-1:0][DATA-1:0] in_vec,
    output logic [IN-1:0]           out_vec
);
    localparam int IW = (IN > 1) ? $clog2(IN) : 1;

    logic [DATA-1:0] w_best;
    logic [IW-1:0]   w_idx;
    logic [IN-1:0]   w_onehot;

    // Strict comparison only, so an equal key never displaces an earlier index.
    always_comb begin
        w_best = in_vec[0];
        w_idx  = '0;
        for (int i = 1; i < IN; i++) begin
            if ((MINMAX_ == HIGH) ? (in_vec[i] < w_best) : (in_vec[i] > w_best)) begin
                w_best = in_vec[i];
                w_idx  = IW'(i);
            end
        end
        w_onehot        = '0;
        w_onehot[w_idx] = 1'b1;
    end

    assign out_vec = (ACT == HIGH) ? w_onehot : ~w_onehot;
endmodule

// File: rtl/minmax_pbuf.sv
// Priority buffer. It holds up to DEPTH keys and always shows the minimum key
// (MINMAX_=HIGH) or the maximum key (MINMAX_=LOW) at its output.
//   clk, reset_            : clock, async active-low reset
//   flush                  : synchronous clear. It has priority over push and pop.
//   in_valid/in_ready/in_data    : push side. in_ready = !full.
//   out_valid/out_ready/out_data : pop side. out_data = 0 when the buffer is empty.
//   count                  : number of occupied slots
module minmax_pbuf
    import minmax_pbuf_pkg::*;
#(
    parameter bit MINMAX_ = HIGH,
    parameter int DEPTH   = 8,
    parameter int DATA    = 8,
    parameter int CNT     = $clog2(DEPTH+1)
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic [CNT-1:0]  count
);
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0][DATA-1:0] r_data;
    logic [CNT-1:0]             r_count;

    logic [DEPTH-1:0][DATA:0]   w_keys;
    logic [DEPTH-1:0]           w_sel;
    logic [DEPTH-1:0]           w_free;
    logic                       w_found;
    logic [DATA-1:0]            w_sel_data;
    logic                       w_push;
    logic                       w_pop;

    // An empty slot gets the worst possible MSB. It then loses against any real key,
    // even against all-zero or all-one data.
    function automatic logic [DATA:0] ext_key(input logic v, input logic [DATA-1:0] d);
        return (MINMAX_ == HIGH) ? {~v, d} : {v, d};
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) w_keys[i] = ext_key(r_valid[i], r_data[i]);
    end

    sel_minmax #(
        .IN      (DEPTH),
        .DATA    (DATA+1),
        .MINMAX_ (MINMAX_),
        .ACT     (HIGH)
    ) u_sel (
        .in_vec  (w_keys),
        .out_vec (w_sel)
    );

    // Lowest free slot. It is found from the pre-pop valid bits, so a slot freed
    // by a pop in the same cycle is never reused in that cycle.
    always_comb begin
        w_free  = '0;
        w_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !w_found) begin
                w_free[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    // AND-OR mux of the selected slot. w_sel is one-hot.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < DEPTH; i++) w_sel_data |= r_data[i] & {DATA{w_sel[i]}};
    end

    assign in_ready  = (r_count != CNT'(DEPTH));
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? w_sel_data : '0;
    assign count     = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_valid <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= (r_valid & ~(w_pop ? w_sel : '0)) | (w_push ? w_free : '0);
            r_count <= r_count + CNT'(w_push) - CNT'(w_pop);
        end
    end

    // Slot payload needs no reset. Stale data is masked by the valid bits.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && w_free[i]) r_data[i] <= in_data;
        end
    end
endmodule

// File: tb/tb_minmax_pbuf.sv
module tb_minmax_pbuf;
    import minmax_pbuf_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;

    logic       ir_hi, ov_hi, ir_lo, ov_lo;
    logic [7:0] od_hi, od_lo;
    logic [2:0] cnt_hi, cnt_lo;

    bit         sel_lo = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         m[$];
    int         exp_q[$];

    always #5 clk = ~clk;

    minmax_pbuf #(.MINMAX_(HIGH), .DEPTH(D), .DATA(8)) u_hi (
        .clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid), .in_ready(ir_hi),
        .in_data(in_data), .out_valid(ov_hi), .out_ready(out_ready), .out_data(od_hi), .count(cnt_hi)
    );
    minmax_pbuf #(.MINMAX_(LOW), .DEPTH(D), .DATA(8)) u_lo (
        .clk(clk), .reset_(reset_), .flush(flush), .in_valid(in_valid), .in_ready(ir_lo),
        .in_data(in_data), .out_valid(ov_lo), .out_ready(out_ready), .out_data(od_lo), .count(cnt_lo)
    );

    wire       w_ir  = sel_lo ? ir_lo  : ir_hi;
    wire       w_ov  = sel_lo ? ov_lo  : ov_hi;
    wire [7:0] w_od  = sel_lo ? od_lo  : od_hi;
    wire [2:0] w_cnt = sel_lo ? cnt_lo : cnt_hi;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int best();
        int b = m[0];
        foreach (m[i]) if (sel_lo ? (m[i] > b) : (m[i] < b)) b = m[i];
        return b;
    endfunction

    // Called at a falling edge. It checks the visible state, drives one cycle of
    // stimulus, updates the reference model, and returns at the next falling edge.
    task automatic step(input bit pu, input int d, input bit po, input bit fl);
        int sz = m.size();
        int b;
        check("count", int'(w_cnt), sz);
        check("in_ready", int'(w_ir), int'(sz < D));
        check("out_valid", int'(w_ov), int'(sz > 0));
        check("out_data", int'(w_od), (sz > 0) ? best() : 0);
        in_valid = pu; in_data = d[7:0]; out_ready = po; flush = fl;
        #1;
        if (fl) begin
            m.delete();
        end else begin
            if (po && sz > 0) begin
                b = best();
                exp_q.push_back(b);
                foreach (m[i]) if (m[i] == b) begin m.delete(i); break; end
            end
            if (w_ov && po) begin
                if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
                else check("pop_data", int'(w_od), exp_q.pop_front());
            end
            if (pu && sz < D) m.push_back(d);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        m.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_count", int'(w_cnt), 0);
        check("rst_out_valid", int'(w_ov), 0);
        check("rst_in_ready", int'(w_ir), 1);
        reset_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_run(input int n);
        for (int k = 0; k < n; k++) begin
            int d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) * 85 : $urandom_range(0, 255);
            step($urandom_range(0, 1), d, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        step(0, 0, 0, 0);

        // In-order pops from a scrambled push order
        step(1, 'h30, 0, 0); step(1, 'h10, 0, 0); step(1, 'h20, 0, 0);
        repeat (4) step(0, 0, 1, 0);

        // Full: a push together with a pop is refused
        step(1, 'h50, 0, 0); step(1, 'h60, 0, 0); step(1, 'h70, 0, 0); step(1, 'h80, 0, 0);
        step(1, 'h01, 1, 0);
        repeat (4) step(0, 0, 1, 0);

        // Push with pop: the new key becomes visible one cycle later
        step(1, 'h10, 0, 0); step(1, 'h40, 0, 0);
        step(1, 'h05, 1, 0);
        repeat (3) step(0, 0, 1, 0);

        // Tie and all-ones data with empty slots present
        step(1, 'h40, 0, 0); step(1, 'hFF, 0, 0); step(1, 'h40, 0, 0);
        repeat (3) step(0, 0, 1, 0);

        // All-zero data must still beat the empty slots
        step(1, 'h00, 0, 0); step(0, 0, 1, 0);

        // Flush wins over a push and a pop in the same cycle
        step(1, 'h22, 0, 0); step(1, 'h11, 0, 0);
        step(1, 'h33, 1, 1);
        step(0, 0, 0, 0);

        // Asynchronous reset in the middle of a cycle
        step(1, 'h44, 0, 0); step(1, 'h55, 0, 0);
        #2 reset_ = 1'b0;
        #1;
        check("async_rst_count", int'(w_cnt), 0);
        check("async_rst_out_valid", int'(w_ov), 0);
        check("async_rst_in_ready", int'(w_ir), 1);
        m.delete(); exp_q.delete();
        @(negedge clk);
        reset_ = 1'b1;
        @(negedge clk);
        step(0, 0, 1, 0);

        rand_run(1000);

        // Max-first instance
        sel_lo = 1'b1;
        do_reset();
        step(1, 'h00, 0, 0); step(1, 'h7F, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        step(1, 'h12, 0, 0); step(1, 'h34, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        rand_run(400);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
